tile_load_sched: RTL and testbench
==================================

TILE_LOAD_SCHED -- requirements
Module: tile_load_sched

Interface
REQ-001 clock  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 cmd_valid  input  1  tile-load command present.
REQ-004 cmd_ready  output  1  command accepted on the cycle cmd_valid and cmd_ready are both high.
REQ-005 cmd_wgt_load  input  1  command also reloads the weights.
REQ-006 cmd_ifm_base_addr  input  16; cmd_ifm_big_length  input  8; cmd_ifm_length  input  6; cmd_ifm_height  input  6 -- ifmap transfer geometry.
REQ-007 cmd_wgt_base_addr  input  8; cmd_wgt_big_length  input  8; cmd_wgt_length  input  6; cmd_wgt_height  input  6 -- weight transfer geometry.
REQ-008 ifm_trans_start  output  1; ifm_trans_end  input  1 -- start pulse to the ifmap glb-to-local engine and its completion pulse.
REQ-009 ifm_base_addr 16, ifm_big_length 8, ifm_length 6, ifm_height 6  outputs -- latched ifmap parameters to that engine.
REQ-010 wgt_trans_start  output  1; wgt_trans_end  input  1; wgt_base_addr 8, wgt_big_length 8, wgt_length 6, wgt_height 6  outputs -- the same set for the shared weight engines.
REQ-011 buf_release  input  1; buf_release_bank  input  1 -- the consumer frees one local ifmap bank.
REQ-012 tile_ready  output  1; tile_bank  output  1 -- one-cycle pulse: the named bank now holds a complete tile.
REQ-013 bank_full  output  2 -- per-bank occupancy flags; busy  output  1 -- FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, WGT_XFER, IFM_XFER and DONE.
REQ-015 cmd_ready SHALL equal (state==IDLE) AND NOT bank_full[wr_bank], where wr_bank is an internal 1-bit pointer.
REQ-016 On accept, all cmd_* fields SHALL be latched into the parameter outputs.
REQ-017 On accept, the next state SHALL be WGT_XFER if cmd_wgt_load is set, else IFM_XFER.
REQ-018 The parameter outputs SHALL stay stable until the next accept.
REQ-019 On the first cycle in WGT_XFER, wgt_trans_start SHALL pulse high for exactly one cycle (the cycle after accept).
REQ-020 The FSM SHALL remain in WGT_XFER until wgt_trans_end is sampled high, then move to IFM_XFER.
REQ-021 On the first cycle in IFM_XFER, ifm_trans_start SHALL pulse high for one cycle.
REQ-022 The FSM SHALL remain in IFM_XFER until ifm_trans_end is sampled high, then move to DONE.
REQ-023 If a trans_end arrives in the same cycle as its own start pulse, it SHALL be honoured; the resulting minimum WGT_XFER/IFM_XFER dwell is 1 cycle.
REQ-024 In DONE (one cycle), the block SHALL:
- pulse tile_ready with tile_bank=wr_bank;
- set bank_full[wr_bank];
- toggle wr_bank;
- return to IDLE.
REQ-025 A trans_end pulse received in any state other than its matching XFER state SHALL be ignored.
REQ-026 buf_release SHALL clear bank_full[buf_release_bank] on the next edge; releasing an already-empty bank is a no-op.
REQ-027 A release and a DONE-set in the same cycle SHALL both take effect.
REQ-028 If a release and a DONE-set target the same bank in the same cycle, set SHALL win.
REQ-029 When both banks are full, cmd_ready SHALL stay low; a command held on cmd_valid SHALL be accepted in the first IDLE cycle after a release frees wr_bank.
REQ-030 cmd_valid held while busy SHALL NOT be accepted, and no command SHALL be dropped or accepted twice.
REQ-031 tile_ready, ifm_trans_start and wgt_trans_start SHALL never be high in the same cycle.

Reset
REQ-032 On rst_n low, asynchronously:
- state=IDLE, wr_bank=0, bank_full=2'b00;
- all pulses, busy and all parameter outputs =0;
- cmd_ready=1 from the first clock after rst_n deasserts.
REQ-033 Reset mid-transfer SHALL abandon the transfer; no tile_ready SHALL be issued for it.

Structure
REQ-034 The state encoding and the parameter field widths (16/8/6/6 ifm, 8/8/6/6 wgt) SHALL live in a shared dla package.
REQ-035 The bank-occupancy tracker (bank_full set/clear, wr_bank) SHALL be one sub-module, tile_bank_tracker; the FSM stays in the top.

Verification
REQ-036 Case 1: cmd with wgt_load=1, ifm_base=0x0100, wgt_base=0x20, each engine's end returned 5 cycles after its start -> wgt_trans_start at T+1; ifm_trans_start one cycle after wgt_end; tile_ready (bank 0) one cycle after ifm_end; bank_full=01.
REQ-037 Case 2: cmd with wgt_load=0 -> no wgt_trans_start; ifm_trans_start at T+1.
REQ-038 Case 3: three back-to-back cmds with no release -> tiles land in banks 0 then 1; cmd_ready stays low; the third cmd is accepted one cycle after buf_release(bank 0) and fills bank 0.
REQ-039 Case 4: release(bank 1) in the same cycle as DONE on bank 0 -> bank_full goes from 10 to 01.
REQ-040 Case 5: stray ifm_trans_end while in WGT_XFER -> ignored; the FSM stays in WGT_XFER.
REQ-041 Case 6: rst_n asserted during IFM_XFER -> all outputs reset immediately; no tile_ready after reset deasserts.

Source files
------------

// File: rtl/dla_pkg.sv
// Shared definitions for the tile-load scheduler: FSM state encoding and
// transfer-parameter field widths for the ifmap and weight engines.
package dla_pkg;

  localparam int IFM_ADDR_W = 16;
  localparam int IFM_BIG_W  = 8;
  localparam int IFM_LEN_W  = 6;
  localparam int IFM_HGT_W  = 6;

  localparam int WGT_ADDR_W = 8;
  localparam int WGT_BIG_W  = 8;
  localparam int WGT_LEN_W  = 6;
  localparam int WGT_HGT_W  = 6;

  localparam int NUM_BANKS = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WGT_XFER = 2'd1,
    ST_IFM_XFER = 2'd2,
    ST_DONE     = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [IFM_ADDR_W-1:0] base_addr;
    logic [IFM_BIG_W-1:0]  big_length;
    logic [IFM_LEN_W-1:0]  length;
    logic [IFM_HGT_W-1:0]  height;
  } ifm_param_t;

  typedef struct packed {
    logic [WGT_ADDR_W-1:0] base_addr;
    logic [WGT_BIG_W-1:0]  big_length;
    logic [WGT_LEN_W-1:0]  length;
    logic [WGT_HGT_W-1:0]  height;
  } wgt_param_t;

endpackage

// File: rtl/tile_bank_tracker.sv
// Occupancy tracker for the two local ifmap banks: the write pointer and
// the per-bank full flags, set by a completed tile and cleared by the consumer.
module tile_bank_tracker
  import dla_pkg::*;
(
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 done_set,
  input  logic                 rel_en,
  input  logic                 rel_bank,
  output logic [NUM_BANKS-1:0] bank_full,
  output logic                 wr_bank
);

  logic [NUM_BANKS-1:0] full_next;

  // Clear is applied before set so a same-bank collision leaves the bank full.
  always_comb begin
    full_next = bank_full;
    if (rel_en) begin
      full_next[rel_bank] = 1'b0;
    end
    if (done_set) begin
      full_next[wr_bank] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      bank_full <= '0;
      wr_bank   <= 1'b0;
    end else begin
      bank_full <= full_next;
      if (done_set) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

endmodule

// File: rtl/tile_load_sched.sv
// Tile-load scheduler: accepts a load command, sequences the optional weight
// transfer and the ifmap transfer, then publishes the filled bank to the consumer.
module tile_load_sched
  import dla_pkg::*;
(
  input  logic                  clock,
  input  logic                  rst_n,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wgt_load,
  input  logic [IFM_ADDR_W-1:0] cmd_ifm_base_addr,
  input  logic [IFM_BIG_W-1:0]  cmd_ifm_big_length,
  input  logic [IFM_LEN_W-1:0]  cmd_ifm_length,
  input  logic [IFM_HGT_W-1:0]  cmd_ifm_height,
  input  logic [WGT_ADDR_W-1:0] cmd_wgt_base_addr,
  input  logic [WGT_BIG_W-1:0]  cmd_wgt_big_length,
  input  logic [WGT_LEN_W-1:0]  cmd_wgt_length,
  input  logic [WGT_HGT_W-1:0]  cmd_wgt_height,

  output logic                  ifm_trans_start,
  input  logic                  ifm_trans_end,
  output logic [IFM_ADDR_W-1:0] ifm_base_addr,
  output logic [IFM_BIG_W-1:0]  ifm_big_length,
  output logic [IFM_LEN_W-1:0]  ifm_length,
  output logic [IFM_HGT_W-1:0]  ifm_height,

  output logic                  wgt_trans_start,
  input  logic                  wgt_trans_end,
  output logic [WGT_ADDR_W-1:0] wgt_base_addr,
  output logic [WGT_BIG_W-1:0]  wgt_big_length,
  output logic [WGT_LEN_W-1:0]  wgt_length,
  output logic [WGT_HGT_W-1:0]  wgt_height,

  input  logic                  buf_release,
  input  logic                  buf_release_bank,

  output logic                  tile_ready,
  output logic                  tile_bank,
  output logic [NUM_BANKS-1:0]  bank_full,
  output logic                  busy
);

  sched_state_t state;
  sched_state_t state_next;
  logic         first_cycle;
  logic         accept;
  logic         wr_bank;
  ifm_param_t   ifm_q;
  wgt_param_t   wgt_q;

  assign cmd_ready = (state == ST_IDLE) && !bank_full[wr_bank];
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != ST_IDLE);
  assign tile_bank = wr_bank;

  // first_cycle marks the first cycle spent in a newly entered state; the
  // start pulses key off it so a same-cycle trans_end still sees its start.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      first_cycle <= 1'b0;
    end else begin
      state       <= state_next;
      first_cycle <= (state_next != state);
    end
  end

  always_comb begin
    state_next      = state;
    wgt_trans_start = 1'b0;
    ifm_trans_start = 1'b0;
    tile_ready      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = cmd_wgt_load ? ST_WGT_XFER : ST_IFM_XFER;
        end
      end
      ST_WGT_XFER: begin
        wgt_trans_start = first_cycle;
        if (wgt_trans_end) begin
          state_next = ST_IFM_XFER;
        end
      end
      ST_IFM_XFER: begin
        ifm_trans_start = first_cycle;
        if (ifm_trans_end) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        tile_ready = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ifm_q <= '0;
      wgt_q <= '0;
    end else if (accept) begin
      ifm_q <= '{base_addr:  cmd_ifm_base_addr,
                 big_length: cmd_ifm_big_length,
                 length:     cmd_ifm_length,
                 height:     cmd_ifm_height};
      wgt_q <= '{base_addr:  cmd_wgt_base_addr,
                 big_length: cmd_wgt_big_length,
                 length:     cmd_wgt_length,
                 height:     cmd_wgt_height};
    end
  end

  assign ifm_base_addr  = ifm_q.base_addr;
  assign ifm_big_length = ifm_q.big_length;
  assign ifm_length     = ifm_q.length;
  assign ifm_height     = ifm_q.height;
  assign wgt_base_addr  = wgt_q.base_addr;
  assign wgt_big_length = wgt_q.big_length;
  assign wgt_length     = wgt_q.length;
  assign wgt_height     = wgt_q.height;

  tile_bank_tracker u_tracker (
    .clock     (clock),
    .rst_n     (rst_n),
    .done_set  (tile_ready),
    .rel_en    (buf_release),
    .rel_bank  (buf_release_bank),
    .bank_full (bank_full),
    .wr_bank   (wr_bank)
  );

endmodule

// File: tb/tb_tile_load_sched.sv
// Randomized bench for tile_load_sched: an event-schedule reference model
// predicts every pulse, flag and latched parameter cycle by cycle.
module tb_tile_load_sched;

  logic        clock = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wgt_load = 1'b0;
  logic [15:0] cmd_ifm_base_addr = '0;
  logic [7:0]  cmd_ifm_big_length = '0;
  logic [5:0]  cmd_ifm_length = '0;
  logic [5:0]  cmd_ifm_height = '0;
  logic [7:0]  cmd_wgt_base_addr = '0;
  logic [7:0]  cmd_wgt_big_length = '0;
  logic [5:0]  cmd_wgt_length = '0;
  logic [5:0]  cmd_wgt_height = '0;
  logic        ifm_trans_start;
  logic        ifm_trans_end = 1'b0;
  logic [15:0] ifm_base_addr;
  logic [7:0]  ifm_big_length;
  logic [5:0]  ifm_length;
  logic [5:0]  ifm_height;
  logic        wgt_trans_start;
  logic        wgt_trans_end = 1'b0;
  logic [7:0]  wgt_base_addr;
  logic [7:0]  wgt_big_length;
  logic [5:0]  wgt_length;
  logic [5:0]  wgt_height;
  logic        buf_release = 1'b0;
  logic        buf_release_bank = 1'b0;
  logic        tile_ready;
  logic        tile_bank;
  logic [1:0]  bank_full;
  logic        busy;

  always #5 clock = ~clock;

  tile_load_sched dut (
    .clock              (clock),
    .rst_n              (rst_n),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_wgt_load       (cmd_wgt_load),
    .cmd_ifm_base_addr  (cmd_ifm_base_addr),
    .cmd_ifm_big_length (cmd_ifm_big_length),
    .cmd_ifm_length     (cmd_ifm_length),
    .cmd_ifm_height     (cmd_ifm_height),
    .cmd_wgt_base_addr  (cmd_wgt_base_addr),
    .cmd_wgt_big_length (cmd_wgt_big_length),
    .cmd_wgt_length     (cmd_wgt_length),
    .cmd_wgt_height     (cmd_wgt_height),
    .ifm_trans_start    (ifm_trans_start),
    .ifm_trans_end      (ifm_trans_end),
    .ifm_base_addr      (ifm_base_addr),
    .ifm_big_length     (ifm_big_length),
    .ifm_length         (ifm_length),
    .ifm_height         (ifm_height),
    .wgt_trans_start    (wgt_trans_start),
    .wgt_trans_end      (wgt_trans_end),
    .wgt_base_addr      (wgt_base_addr),
    .wgt_big_length     (wgt_big_length),
    .wgt_length         (wgt_length),
    .wgt_height         (wgt_height),
    .buf_release        (buf_release),
    .buf_release_bank   (buf_release_bank),
    .tile_ready         (tile_ready),
    .tile_bank          (tile_bank),
    .bank_full          (bank_full),
    .busy               (busy)
  );

  typedef struct {
    bit          wgt;
    logic [35:0] ifm;
    logic [27:0] wts;
  } cmd_t;

  int checks = 0;
  int failures = 0;

  // Reference model: a transaction is a set of scheduled event cycles.
  cmd_t        cmd_q[$];
  int          cyc = 0;
  bit          m_busy, m_wait_wgt, m_wait_ifm, m_wr;
  bit [1:0]    m_full;
  int          wgt_start_at, ifm_start_at, tile_at, wgt_end_at, ifm_end_at;
  logic [35:0] m_ifm;
  logic [27:0] m_wts;

  // Stimulus knobs.
  bit auto_cmd = 0;
  int rel_pct = 0;
  int stray_pct = 0;
  int lat_fixed = 1;
  bit rel_once = 0, rel_once_bank = 0;
  bit rel_on_done = 0, rel_on_done_bank = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic cmd_t randCmd();
    cmd_t c;
    c.wgt = 1'($urandom_range(0, 1));
    c.ifm = {4'($urandom), 32'($urandom)};
    c.wts = 28'($urandom);
    return c;
  endfunction

  function automatic bit roll(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  function automatic int pickLat();
    return (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 4));
  endfunction

  task automatic queueCmd(input bit wgt, input logic [15:0] ib, input logic [7:0] wb);
    cmd_t c;
    c = randCmd();
    c.wgt = wgt;
    c.ifm[35:20] = ib;
    c.wts[27:20] = wb;
    cmd_q.push_back(c);
  endtask

  task automatic modelReset();
    m_busy = 0; m_wait_wgt = 0; m_wait_ifm = 0; m_wr = 0; m_full = 2'b00;
    wgt_start_at = -1; ifm_start_at = -1; tile_at = -1;
    wgt_end_at = -1; ifm_end_at = -1;
    m_ifm = '0; m_wts = '0;
    cmd_q.delete();
  endtask

  task automatic checkCycle();
    checkOutput("pulses", {61'd0, wgt_trans_start, ifm_trans_start, tile_ready},
                {61'd0, cyc == wgt_start_at, cyc == ifm_start_at, cyc == tile_at});
    checkOutput("busy", busy, m_busy);
    checkOutput("cmd_ready", cmd_ready, !m_busy && !m_full[m_wr]);
    checkOutput("bank_full", bank_full, m_full);
    checkOutput("ifm_params", {ifm_base_addr, ifm_big_length, ifm_length, ifm_height}, m_ifm);
    checkOutput("wgt_params", {wgt_base_addr, wgt_big_length, wgt_length, wgt_height}, m_wts);
    if (cyc == tile_at) checkOutput("tile_bank", tile_bank, m_wr);
  endtask

  task automatic driveInputs();
    cmd_t c;
    if (auto_cmd && cmd_q.size() == 0 && roll(40)) cmd_q.push_back(randCmd());
    c = (cmd_q.size() > 0) ? cmd_q[0] : randCmd();
    cmd_valid = (cmd_q.size() > 0);
    cmd_wgt_load = c.wgt;
    {cmd_ifm_base_addr, cmd_ifm_big_length, cmd_ifm_length, cmd_ifm_height} = c.ifm;
    {cmd_wgt_base_addr, cmd_wgt_big_length, cmd_wgt_length, cmd_wgt_height} = c.wts;
    wgt_trans_end = m_wait_wgt ? (cyc == wgt_end_at) : roll(stray_pct);
    ifm_trans_end = m_wait_ifm ? (cyc == ifm_end_at) : roll(stray_pct);
    buf_release = 1'b0;
    buf_release_bank = 1'($urandom_range(0, 1));
    if (rel_once) begin
      buf_release = 1'b1; buf_release_bank = rel_once_bank; rel_once = 0;
    end else if (rel_on_done && cyc == tile_at) begin
      buf_release = 1'b1; buf_release_bank = rel_on_done_bank; rel_on_done = 0;
    end else if (roll(rel_pct)) begin
      buf_release = 1'b1;
    end
  endtask

  task automatic updateModel();
    bit acc;
    int lat;
    acc = cmd_valid && !m_busy && !m_full[m_wr];
    if (m_wait_wgt && wgt_trans_end) begin
      m_wait_wgt = 0; m_wait_ifm = 1;
      ifm_start_at = cyc + 1; ifm_end_at = cyc + 1 + pickLat();
    end else if (m_wait_ifm && ifm_trans_end) begin
      m_wait_ifm = 0; tile_at = cyc + 1;
    end
    if (buf_release) m_full[buf_release_bank] = 1'b0;
    if (cyc == tile_at) begin
      m_full[m_wr] = 1'b1; m_wr = !m_wr; m_busy = 0;
    end
    if (acc) begin
      m_busy = 1;
      m_ifm = cmd_q[0].ifm;
      m_wts = cmd_q[0].wts;
      lat = pickLat();
      if (cmd_q[0].wgt) begin
        m_wait_wgt = 1; wgt_start_at = cyc + 1; wgt_end_at = cyc + 1 + lat;
      end else begin
        m_wait_ifm = 1; ifm_start_at = cyc + 1; ifm_end_at = cyc + 1 + lat;
      end
      void'(cmd_q.pop_front());
    end
  endtask

  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      checkCycle();
      driveInputs();
      updateModel();
      cyc++;
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    cmd_valid = 0; ifm_trans_end = 0; wgt_trans_end = 0; buf_release = 0;
    #1;
    checkOutput("rst_ctrl", {busy, wgt_trans_start, ifm_trans_start, tile_ready, tile_bank, bank_full}, 7'd0);
    checkOutput("rst_ifm_params", {ifm_base_addr, ifm_big_length, ifm_length, ifm_height}, 36'd0);
    checkOutput("rst_wgt_params", {wgt_base_addr, wgt_big_length, wgt_length, wgt_height}, 28'd0);
    modelReset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  initial begin
    modelReset();
    #2;
    doReset();

    $display("[TB] case 1: weight + ifmap load, 5-cycle engines");
    lat_fixed = 5;
    queueCmd(1'b1, 16'h0100, 8'h20);
    applyStimulus(20);
    checkOutput("case1_bank_full", bank_full, 2'b01);

    $display("[TB] case 2: ifmap-only load");
    lat_fixed = 2;
    queueCmd(1'b0, 16'h0BEE, 8'h11);
    applyStimulus(10);
    checkOutput("case2_bank_full", bank_full, 2'b11);

    $display("[TB] case 3: three commands, no release");
    doReset();
    lat_fixed = 1;
    queueCmd(1'b1, 16'h1000, 8'h01);
    queueCmd(1'b0, 16'h2000, 8'h02);
    queueCmd(1'b1, 16'h3000, 8'h03);
    applyStimulus(20);
    checkOutput("case3_full_blocked", {bank_full, cmd_ready}, 3'b110);
    checkOutput("case3_held", cmd_q.size(), 1);
    rel_once = 1; rel_once_bank = 0;
    applyStimulus(12);
    checkOutput("case3_third_in_bank0", bank_full, 2'b11);
    checkOutput("case3_drained", cmd_q.size(), 0);

    $display("[TB] case 4: release bank 1 while bank 0 completes");
    doReset();
    queueCmd(1'b0, 16'h0040, 8'h04);
    queueCmd(1'b0, 16'h0050, 8'h05);
    applyStimulus(12);
    rel_once = 1; rel_once_bank = 0;
    applyStimulus(2);
    checkOutput("case4_before", bank_full, 2'b10);
    rel_on_done = 1; rel_on_done_bank = 1;
    queueCmd(1'b1, 16'h0060, 8'h06);
    applyStimulus(10);
    checkOutput("case4_after", bank_full, 2'b01);

    $display("[TB] case 5: stray ifmap end during weight transfer");
    doReset();
    lat_fixed = 6; stray_pct = 100;
    queueCmd(1'b1, 16'h0070, 8'h07);
    applyStimulus(4);
    checkOutput("case5_still_wgt", {busy, ifm_trans_start}, 2'b10);
    applyStimulus(14);
    stray_pct = 0;

    $display("[TB] case 6: reset during ifmap transfer");
    doReset();
    lat_fixed = 10;
    queueCmd(1'b0, 16'h0080, 8'h08);
    applyStimulus(4);
    doReset();
    applyStimulus(20);

    $display("[TB] random traffic");
    doReset();
    auto_cmd = 1; rel_pct = 20; stray_pct = 15; lat_fixed = -1;
    applyStimulus(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
